// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and one-hot decode helper for the
// eight-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned PTR_W = 3;

    typedef enum logic {
        IDLE,
        OWN
    } state_e;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] v);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) idx = idx | PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The masked copy sits in the low half so it wins over the unmasked wrap copy.
module rr_pick_8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic             any
);

    logic [N_REQ-1:0]   masked;
    logic [2*N_REQ-1:0] dbl;
    logic [PTR_W-1:0]   idx;

    always_comb begin
        masked = req & ~((N_REQ'(1) << ptr) - N_REQ'(1));
        dbl    = {req, masked};
        idx    = '0;
        any    = 1'b0;
        // Scan downward so the lowest set position is the last one written.
        for (int j = 2 * N_REQ - 1; j >= 0; j--) begin
            if (dbl[j]) begin
                idx = PTR_W'(j);
                any = 1'b1;
            end
        end
        pick      = '0;
        pick[idx] = any;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with registered one-hot grant,
// owner release on done / request drop, and optional hold timeout.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic             timeout_q;
    logic [PTR_W-1:0] ptr_q;
    logic [HOLD_W-1:0] cnt_q;

    logic [PTR_W-1:0] owner;
    logic             hold_max;
    logic             vol_rel;
    logic             rel;
    logic             forced;
    logic [PTR_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_req;
    logic [N_REQ-1:0] pick;
    logic             any;

    always_comb begin
        owner    = onehot_to_idx(gnt_q);
        hold_max = (MAX_HOLD != 0) && (cnt_q == HoldLast);
        vol_rel  = done || !req[owner];
        rel      = (state_q == OWN) && (vol_rel || hold_max);
        forced   = (state_q == OWN) && !vol_rel && hold_max;
        // On release the old owner is masked and the search starts just past it.
        pick_ptr = rel ? owner + PTR_W'(1) : ptr_q;
        pick_req = rel ? (req & ~gnt_q) : req;
    end

    rr_pick_8 u_pick (
        .req  (pick_req),
        .ptr  (pick_ptr),
        .pick (pick),
        .any  (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            timeout_q <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                gnt_q   <= '0;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (any) begin
                            gnt_q   <= pick;
                            state_q <= OWN;
                            cnt_q   <= '0;
                        end
                    end
                    OWN: begin
                        if (rel) begin
                            ptr_q     <= pick_ptr;
                            timeout_q <= forced;
                            gnt_q     <= pick;
                            cnt_q     <= '0;
                            state_q   <= any ? OWN : IDLE;
                        end else if (MAX_HOLD != 0 && !hold_max) begin
                            cnt_q <= cnt_q + HOLD_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: owner index (-1 = none), priority pointer, cycles the
    // current grant has been visible, and the forced-release flag.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    rr_arbiter_8 #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int search(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_gnt();
        logic [7:0] g;
        g = 8'h00;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (!en) begin
                m_owner = -1;
                m_held  = 0;
            end else if (m_owner < 0) begin
                m_owner = search(req, m_ptr);
                m_held  = (m_owner >= 0) ? 1 : 0;
            end else begin
                bit         vol;
                bit         frc;
                logic [7:0] masked;
                vol = done || !req[m_owner];
                frc = !vol && (MAX_HOLD != 0) && (m_held >= MAX_HOLD);
                if (vol || frc) begin
                    m_ptr  = (m_owner + 1) % 8;
                    m_to   = frc;
                    masked = req;
                    masked[m_owner] = 1'b0;
                    m_owner = search(masked, m_ptr);
                    m_held  = (m_owner >= 0) ? 1 : 0;
                end else begin
                    m_held++;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_gnt", gnt, model_gnt());
        check("model_gnt_valid", {7'b0, gnt_valid}, {7'b0, m_owner >= 0});
        check("model_timeout", {7'b0, timeout}, {7'b0, m_to});
    end

    task automatic step(input logic e, input logic [7:0] r, input logic d);
        en   = e;
        req  = r;
        done = d;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_gnt", gnt, 8'h00);
        check("reset_valid", {7'b0, gnt_valid}, 8'h00);
        check("reset_timeout", {7'b0, timeout}, 8'h00);

        rst_n = 1'b1;
        step(1'b1, 8'h05, 1'b0);
        check("first_grant", gnt, 8'h01);
        check("first_valid", {7'b0, gnt_valid}, 8'h01);

        step(1'b1, 8'h81, 1'b1);
        check("rr_to_7", gnt, 8'h80);
        step(1'b1, 8'h81, 1'b1);
        check("rr_to_0", gnt, 8'h01);
        step(1'b1, 8'h81, 1'b1);
        check("rr_to_7_again", gnt, 8'h80);

        // ptr is now 1; drop en to clear, then hold 0x06 until timeout.
        step(1'b0, 8'h00, 1'b0);
        check("en_low_clear", gnt, 8'h00);
        step(1'b1, 8'h06, 1'b0);
        check("to_grant_1", gnt, 8'h02);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h06, 1'b0);
            check("to_hold", gnt, 8'h02);
            check("to_no_pulse", {7'b0, timeout}, 8'h00);
        end
        step(1'b1, 8'h06, 1'b0);
        check("to_switch", gnt, 8'h04);
        check("to_pulse", {7'b0, timeout}, 8'h01);
        step(1'b1, 8'h06, 1'b0);
        check("to_pulse_end", {7'b0, timeout}, 8'h00);

        step(1'b1, 8'h10, 1'b1);
        check("en_setup", gnt, 8'h10);
        step(1'b0, 8'h10, 1'b0);
        check("en_drop", gnt, 8'h00);
        step(1'b1, 8'h10, 1'b0);
        check("en_reraise", gnt, 8'h10);

        step(1'b1, 8'h08, 1'b1);
        check("drop_setup", gnt, 8'h08);
        step(1'b1, 8'h00, 1'b0);
        check("owner_drop", gnt, 8'h00);
        step(1'b1, 8'h11, 1'b0);
        check("ptr_after_drop", gnt, 8'h10);

        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", gnt, 8'h00);
        check("async_rst_valid", {7'b0, gnt_valid}, 8'h00);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ptr_after_reset", gnt, 8'h01);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) req = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            done = ($urandom_range(0, 5) == 0);
            en   = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Eight-requester round-robin arbiter. It produces a registered one-hot grant vector.
- The grant vector drives the data input of the 8-to-3 encoder stage directly downstream. The encoder's enable is tied to gnt_valid.
- The grant is held until the owner releases it, or until a hold timeout fires.
- Only one-hot or all-zero patterns ever leave this block, so the encoder never sees an undefined code.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8 for this release; the encoder width depends on it.
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held before forced release. 0 disables the timeout.
- HOLD_W, 5, width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbiter enable; low forces the grant off
- req  input  8  request vector; bit i = requester i wants ownership
- done  input  1  single-cycle release pulse from the current grant owner
- gnt  output  8  registered one-hot grant; all zero when no owner
- gnt_valid  output  1  high exactly when gnt is non-zero
- timeout  output  1  one-cycle pulse in the cycle a forced release is registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=0, gnt_valid=0, timeout=0.
  - State IDLE, round-robin pointer ptr=0, hold counter=0.
- ptr (3 bits) is the highest-priority index. Search order is ptr, ptr+1, …, ptr+7, modulo 8.
- States: IDLE, OWN.
- IDLE:
  - Condition: en=1 and req has at least one bit set.
  - Action: pick the first set bit in search order, register it into gnt and set gnt_valid.
  - Next state OWN; hold counter cleared.
  - Latency from request to grant is 1 cycle.
  - Otherwise gnt stays 0.
- OWN (owner index k): the grant is held while none of the release conditions below apply. Release conditions:
  - (a) done=1.
  - (b) req[k]=0.
  - (c) MAX_HOLD!=0 and the hold counter reaches MAX_HOLD-1 while still owned. This is a forced release; timeout=1 in the next cycle.
- On release:
  - ptr becomes (k+1) mod 8.
  - Re-arbitration happens in the same cycle using the new ptr and req with bit k masked.
  - If any masked request remains, the new one-hot grant appears the next cycle with no idle bubble, and the state stays OWN.
  - Otherwise gnt=0 and the state goes to IDLE.
- Hold counter:
  - Increments each cycle in OWN.
  - Saturates at MAX_HOLD-1.
  - Clears on every new grant.
- en deasserted in any state:
  - Next cycle gnt=0, gnt_valid=0, state IDLE, hold counter cleared.
  - ptr is retained and does not advance.
  - en taking priority over a simultaneous done is legal; no pointer update happens.
- done while in IDLE is ignored. Simultaneous done and req[k] drop counts as one release.
- gnt never has more than one bit set. gnt_valid equals the OR of gnt at all times.
- Reset asserted mid-grant: outputs clear immediately, asynchronously; ptr returns to 0.

Decomposition:
- Package arb_pkg:
  - N_REQ=8 and PTR_W=3 constants.
  - State typedef with values IDLE and OWN.
- One combinational sub-module, rr_pick_8:
  - Inputs: req[7:0] and ptr[2:0].
  - Outputs: the one-hot pick[7:0] and any.
  - Implemented as a double-width masked priority search.
- The top level holds the FSM, ptr, the hold counter and the output registers.

Test Plan:
- Reset release with req=8'b0000_0101, en=1, ptr=0: gnt=8'b0000_0001 one cycle later, and gnt_valid=1.
- Round-robin, req held at 8'b1000_0001, done pulsed after each grant: grants alternate 0x01, 0x80, 0x01, with no idle cycle between them.
- Timeout with MAX_HOLD=4 and req=0x06 held, done never asserted:
  - 0x02 is held 4 cycles, then timeout pulses.
  - gnt switches to 0x04 on the following cycle.
- en dropped while gnt=0x10: gnt=0 next cycle. With req=0x10 still high, en re-raised: gnt=0x10 again, showing ptr was unchanged.
- Owner drops req: req 0x08 -> 0x00 while owning, with no other requests. gnt=0 next cycle, state IDLE, ptr=4.
- Asynchronous reset pulsed mid-OWN between clock edges: gnt and gnt_valid go to 0 immediately. The next arbitration starts from ptr=0.
